// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IMEM_LOADER_HALT_APPEND_EN adds the HALT state used to append a halt instruction.
package imem_loader_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam logic [31:0] HALT_INSN     = 32'h0000_007F;

    typedef logic [1:0] lane_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
`ifdef IMEM_LOADER_HALT_APPEND_EN
        S_HALT,
`endif
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and IMEM write-port bundle; master is the loader side.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    modport master (input rx_data, rx_valid, output we, waddr, wdata);
    modport slave  (output rx_data, rx_valid, input we, waddr, wdata);
endinterface

// File: rtl/imem_word_assembler.sv
// Packs incoming bytes little-endian into 32-bit words, keeps the running XOR
// checksum and pulses word_valid the cycle after the fourth byte of each word.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output lane_t       lane,
    output logic [31:0] word,
    output logic        word_valid,
    output logic [7:0]  checksum
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane       <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            checksum   <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane     <= '0;
                checksum <= '0;
            end else if (byte_en) begin
                word[{lane, 3'b000} +: 8] <= byte_in;
                lane                      <= lane + 2'd1;
                checksum                  <= checksum ^ byte_in;
                word_valid                <= (lane == 2'd3);
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Frame parser that loads a checksum-verified image into IMEM and releases the core.
// Define IMEM_LOADER_HALT_APPEND_EN to reserve one slot and append a halt word after the image.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter int         DEPTH     = 32,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    imem_loader_if.master     bus,
    output logic              cpu_rst_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_cnt
);

`ifdef IMEM_LOADER_HALT_APPEND_EN
    localparam int MAX_N = DEPTH - 1;
`else
    localparam int MAX_N = DEPTH;
`endif

    state_t            state, state_next;
    logic [7:0]        n;
    logic [ADDR_W-1:0] waddr_q;
    logic              accept_sync, byte_en, last_byte, frame_full;
    lane_t             lane;
    logic [31:0]       word;
    logic              word_valid;
    logic [7:0]        checksum;

    assign accept_sync = bus.rx_valid && (bus.rx_data == SYNC_BYTE) &&
                         (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign byte_en     = bus.rx_valid && (state == S_DATA);
    assign last_byte   = byte_en && (lane == 2'd3);
    // word_cnt still holds the pre-increment count while the last byte is sampled
    assign frame_full  = (32'(word_cnt) + 32'd1) == 32'(n);

    imem_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept_sync),
        .byte_en    (byte_en),
        .byte_in    (bus.rx_data),
        .lane       (lane),
        .word       (word),
        .word_valid (word_valid),
        .checksum   (checksum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (accept_sync) state_next = S_LEN;
            end
            S_LEN: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == 8'd0)              state_next = S_CHK;
                    else if (int'(bus.rx_data) > MAX_N)   state_next = S_ERR;
                    else                                  state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (last_byte && frame_full) state_next = S_CHK;
            end
            S_CHK: begin
                if (bus.rx_valid) begin
`ifdef IMEM_LOADER_HALT_APPEND_EN
                    state_next = (bus.rx_data == checksum) ? S_HALT : S_ERR;
`else
                    state_next = (bus.rx_data == checksum) ? S_DONE : S_ERR;
`endif
                end
            end
`ifdef IMEM_LOADER_HALT_APPEND_EN
            S_HALT:  state_next = S_DONE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n            <= '0;
            word_cnt     <= '0;
            waddr_q      <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            cpu_rst_hold <= 1'b1;
        end else begin
            if (accept_sync) begin
                word_cnt <= '0;
            end else if (last_byte) begin
                waddr_q  <= word_cnt;
                word_cnt <= word_cnt + ADDR_W'(1);
            end
            if (state == S_LEN && bus.rx_valid) n <= bus.rx_data;
            done         <= (state_next == S_DONE);
            err          <= (state_next == S_ERR);
            cpu_rst_hold <= (state_next != S_DONE);
        end
    end

    always_comb begin
        bus.we    = word_valid;
        bus.waddr = waddr_q;
        bus.wdata = word;
`ifdef IMEM_LOADER_HALT_APPEND_EN
        if (state == S_HALT) begin
            bus.we    = 1'b1;
            bus.waddr = ADDR_W'(n);
            bus.wdata = HALT_INSN;
        end
`endif
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed vector table, timing sequences
// and randomized framed streams checked against a stream-parsing reference model.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 32;
`ifdef IMEM_LOADER_HALT_APPEND_EN
    localparam int HALT_EN = 1;
`else
    localparam int HALT_EN = 0;
`endif
    localparam int          MAX_N = DEPTH - HALT_EN;
    localparam logic [7:0]  SYNC  = 8'hA5;
    localparam logic [31:0] HALT_WORD = 32'h0000_007F;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_rst_hold, done, err;
    logic [ADDR_W-1:0] word_cnt;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .cpu_rst_hold (cpu_rst_hold),
        .done         (done),
        .err          (err),
        .word_cnt     (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        int               len;
        logic [0:15][7:0] b;
        bit               e_done;
        bit               e_err;
        int               e_wc;
        int               e_nwr;
    } vec_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] stream[$];
    int         n_pass = 0;
    int         n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            got_q.push_back('{addr: bus.waddr, data: bus.wdata});
            check("waddr_in_range", 32'(bus.waddr < DEPTH), 32'd1);
        end
    end

    // All driving happens 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        stream.delete();
        got_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        stream.push_back(b);
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Parses everything sent since the last reset, frame by frame.
    task automatic run_model(output bit m_done, output bit m_err, output int m_wc);
        int          i, n;
        logic [7:0]  chk;
        logic [31:0] w;
        exp_q.delete();
        m_done = 0; m_err = 0; m_wc = 0; i = 0;
        while (i < stream.size()) begin
            if (stream[i] != SYNC) begin
                i++;
                continue;
            end
            i++;
            m_done = 0; m_err = 0; m_wc = 0;
            if (i >= stream.size()) break;
            n = int'(stream[i]);
            i++;
            if (n > MAX_N) begin
                m_err = 1;
                continue;
            end
            chk = 8'h00;
            while (m_wc < n && i + 4 <= stream.size()) begin
                w = {stream[i+3], stream[i+2], stream[i+1], stream[i]};
                chk = chk ^ stream[i] ^ stream[i+1] ^ stream[i+2] ^ stream[i+3];
                exp_q.push_back('{addr: ADDR_W'(m_wc), data: w});
                m_wc++;
                i += 4;
            end
            if (m_wc < n || i >= stream.size()) break;
            if (stream[i] == chk) begin
                if (HALT_EN != 0) exp_q.push_back('{addr: ADDR_W'(n), data: HALT_WORD});
                m_done = 1;
            end else begin
                m_err = 1;
            end
            i++;
        end
    endtask

    task automatic compare_model(input string tag);
        bit m_done, m_err;
        int m_wc;
        run_model(m_done, m_err, m_wc);
        check({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_waddr"}, 32'(got_q[i].addr), 32'(exp_q[i].addr));
            check({tag, "_wdata"}, got_q[i].data, exp_q[i].data);
        end
        check({tag, "_done"}, 32'(done), 32'(m_done));
        check({tag, "_err"}, 32'(err), 32'(m_err));
        check({tag, "_hold"}, 32'(cpu_rst_hold), 32'(!m_done));
        check({tag, "_word_cnt"}, 32'(word_cnt), 32'(m_wc));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, 32'(bus.we), 32'd0);
        check({tag, "_waddr"}, 32'(bus.waddr), 32'd0);
        check({tag, "_wdata"}, bus.wdata, 32'd0);
        check({tag, "_hold"}, 32'(cpu_rst_hold), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
    endtask

    task automatic send_random_frame(input int n, input bit bad_chk, input int maxgap);
        logic [7:0] chk, b;
        send_byte(SYNC, $urandom_range(0, maxgap));
        send_byte(n[7:0], $urandom_range(0, maxgap));
        if (n > MAX_N) return;
        chk = 8'h00;
        for (int k = 0; k < 4 * n; k++) begin
            b = 8'($urandom);
            chk ^= b;
            send_byte(b, $urandom_range(0, maxgap));
        end
        if (bad_chk) chk ^= 8'(1 << $urandom_range(0, 7));
        send_byte(chk, $urandom_range(0, maxgap));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[0:5];
        int   n, r;
        logic [7:0] junk;

        vt[0] = '{11, {8'hA5, 8'h02, 8'h13, 8'h05, 8'h60, 8'h00, 8'hEF, 8'h00, 8'h80, 8'h00, 8'h19, {5{8'h00}}},
                  1, 0, 2, 2 + HALT_EN};
        vt[1] = '{11, {8'hA5, 8'h02, 8'h13, 8'h05, 8'h60, 8'h00, 8'hEF, 8'h00, 8'h80, 8'h00, 8'h18, {5{8'h00}}},
                  0, 1, 2, 2};
        vt[2] = '{2, {8'hA5, 8'h21, {14{8'h00}}}, 0, 1, 0, 0};
        vt[3] = '{10, {8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08, {6{8'h00}}},
                  1, 0, 1, 1 + HALT_EN};
        vt[4] = '{3, {8'hA5, 8'h00, 8'h00, {13{8'h00}}}, 1, 0, 0, HALT_EN};
        vt[5] = '{7, {8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, {9{8'h00}}}, 1, 0, 1, 1 + HALT_EN};

        do_reset();
        check_reset_values("reset");

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int k = 0; k < vt[v].len; k++) send_byte(vt[v].b[k], 0);
            settle();
            check($sformatf("vec%0d_done", v), 32'(done), 32'(vt[v].e_done));
            check($sformatf("vec%0d_err", v), 32'(err), 32'(vt[v].e_err));
            check($sformatf("vec%0d_hold", v), 32'(cpu_rst_hold), 32'(!vt[v].e_done));
            check($sformatf("vec%0d_word_cnt", v), 32'(word_cnt), 32'(vt[v].e_wc));
            check($sformatf("vec%0d_nwr", v), 32'(got_q.size()), 32'(vt[v].e_nwr));
            compare_model($sformatf("vec%0d", v));
        end

        // Write latency, single-cycle we and byte accepted during the we cycle.
        do_reset();
        send_byte(8'hA5, 0); send_byte(8'h02, 0);
        send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'h60, 0); send_byte(8'h00, 0);
        check("lat_w0_we", 32'(bus.we), 32'd1);
        check("lat_w0_waddr", 32'(bus.waddr), 32'd0);
        check("lat_w0_wdata", bus.wdata, 32'h0060_0513);
        check("lat_w0_word_cnt", 32'(word_cnt), 32'd1);
        send_byte(8'hEF, 0);
        check("lat_we_pulse", 32'(bus.we), 32'd0);
        send_byte(8'h00, 0); send_byte(8'h80, 0); send_byte(8'h00, 0);
        check("lat_w1_we", 32'(bus.we), 32'd1);
        check("lat_w1_waddr", 32'(bus.waddr), 32'd1);
        check("lat_w1_wdata", bus.wdata, 32'h0080_00EF);
        check("lat_pre_chk_done", 32'(done), 32'd0);
        send_byte(8'h19, 0);
        if (HALT_EN != 0) begin
            check("halt_we", 32'(bus.we), 32'd1);
            check("halt_waddr", 32'(bus.waddr), 32'd2);
            check("halt_wdata", bus.wdata, HALT_WORD);
            check("halt_done_early", 32'(done), 32'd0);
            @(posedge clk);
            #1;
            check("halt_we_after", 32'(bus.we), 32'd0);
        end
        check("lat_done", 32'(done), 32'd1);
        check("lat_hold", 32'(cpu_rst_hold), 32'd0);
        check("lat_err", 32'(err), 32'd0);

        // Length one past capacity is rejected right after LEN.
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'(MAX_N + 1), 0);
        check("toolong_err", 32'(err), 32'd1);
        check("toolong_hold", 32'(cpu_rst_hold), 32'd1);
        settle();
        check("toolong_nwr", 32'(got_q.size()), 32'd0);

        // Asynchronous reset mid-word discards the partial word.
        do_reset();
        send_byte(8'hA5, 0); send_byte(8'h02, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        got_q.delete();
        stream.delete();
        send_byte(8'hA5, 0); send_byte(8'h01, 0);
        send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
        send_byte(8'h08, 0);
        settle();
        check("midrst_nwr", 32'(got_q.size()), 32'(1 + HALT_EN));
        if (got_q.size() > 0) begin
            check("midrst_waddr", 32'(got_q[0].addr), 32'd0);
            check("midrst_wdata", got_q[0].data, 32'h1234_5678);
        end
        check("midrst_done", 32'(done), 32'd1);

        // Randomized streams with junk, gaps and occasional bad lengths/checksums.
        for (int it = 0; it < 25; it++) begin
            do_reset();
            for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
                for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                    junk = 8'($urandom);
                    if (junk == SYNC) junk = 8'h00;
                    send_byte(junk, $urandom_range(0, 2));
                end
                r = $urandom_range(0, 9);
                if (r < 6)      n = $urandom_range(0, 4);
                else if (r < 8) n = $urandom_range(MAX_N - 1, MAX_N + 1);
                else            n = $urandom_range(MAX_N + 1, 255);
                send_random_frame(n, ($urandom_range(0, 3) == 0), 2);
            end
            settle();
            compare_model($sformatf("rand%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. It receives a byte stream, typically from a UART receiver, assembles little-endian 32-bit instruction words and writes them into a writable instruction RAM indexed by word address (same indexing as the fetch `pc`).
- It holds the core in reset until a complete, checksum-verified image is loaded.
- It sits between the serial receiver and the IMEM write port.

Parameters:
- ADDR_W, 8, word-address width (matches the 8-bit `pc`).
- DEPTH, 32, number of writable instruction words; must be ≤ 2**ADDR_W.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid. The loader is always ready; there is no backpressure.
- we  output  1  IMEM write enable, one-cycle pulse.
- waddr  output  ADDR_W  IMEM word address.
- wdata  output  32  IMEM write data.
- cpu_rst_hold  output  1  high holds the core in reset.
- done  output  1  image loaded and verified.
- err  output  1  last frame rejected.
- word_cnt  output  ADDR_W  words written in the current or last frame.

Behaviour:
- Reset values: we=0, waddr=0, wdata=0, cpu_rst_hold=1, done=0, err=0, word_cnt=0. Internal state is IDLE, byte counter 0, checksum 0.
- Frame format: SYNC_BYTE, N (word count, 1 byte), then 4*N data bytes (LSB first per word), then CHK (XOR of all 4*N data bytes).
- FSM: IDLE, LEN, DATA, CHK, HALT (only with the optional feature), DONE, ERR.
- IDLE/DONE/ERR: a rx_valid byte equal to SYNC_BYTE does all of the following and goes to LEN:
  - sets cpu_rst_hold=1;
  - clears done, err, word_cnt, checksum and byte counter.
  - Other bytes are ignored.
- LEN: on rx_valid, latch N.
  - N==0 → CHK.
  - N > DEPTH → ERR.
  - Otherwise → DATA.
- DATA: each rx_valid byte is shifted into byte lane [byte_idx] and XORed into the checksum; byte_idx is 2 bits and wraps.
  - On the 4th byte: the next cycle drives we=1, waddr=word_cnt, wdata=assembled word. word_cnt increments in that same cycle.
  - Write latency: 1 cycle after the 4th byte's rx_valid.
  - Back-to-back rx_valid on consecutive cycles is supported; a byte arriving in the we cycle is accepted normally.
  - When word_cnt reaches N → CHK.
- CHK: on rx_valid, compare the byte with the checksum.
  - Match → DONE, or HALT with the feature.
  - Mismatch → ERR.
- DONE: done=1, cpu_rst_hold=0. Both are registered, asserted the cycle after the CHK byte (or after the HALT write).
- ERR: err=1, cpu_rst_hold stays 1. IMEM contents are undefined; words already written are not rolled back.
- waddr never exceeds DEPTH-1; the LEN check guarantees this.
- rx_valid is ignored while we is driven only in HALT. There is no timeout.
- rst asserted mid-frame: immediately returns to reset values, and any partial word is discarded.

Optional Feature:
- Macro: IMEM_LOADER_HALT_APPEND_EN.
- When defined:
  - N > DEPTH-1 → ERR, so one slot is reserved.
  - After a checksum match, HALT issues one write: we=1, waddr=N, wdata=32'h0000007F (halt opcode). DONE is entered the following cycle.
  - Checksum does not cover the appended word.
- When undefined: there is no HALT state; the image must contain its own halt.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum;
  - SYNC_BYTE default;
  - HALT_INSN = 32'h0000007F;
  - byte-lane index type.
- One sub-module is natural: imem_word_assembler, which shifts bytes in, computes the XOR checksum, and produces a word_valid pulse. The FSM stays in imem_loader.

Test Plan:
- Frame A5,02, 13 05 60 00, EF 00 80 00, CHK=XOR → writes (0,32'h00600513), (1,32'h008000EF); done=1, cpu_rst_hold=0 one cycle after CHK; err=0.
- Same frame with CHK off by one bit → err=1, done=0, cpu_rst_hold=1; both words were still written.
- N=33 with DEPTH=32 → ERR right after the LEN byte; no we pulses.
- Bytes before SYNC (00,FF,12), then a valid 1-word frame → junk ignored; single write at addr 0.
- rst pulsed after 6 data bytes, then a full 1-word frame → no write from the aborted frame; clean load of addr 0.
- With IMEM_LOADER_HALT_APPEND_EN, N=2 valid frame → 3rd write (2,32'h0000007F), done the next cycle; N=32 → err.
